// File: rtl/enemy_grid_renderer.sv
`default_nettype none
// ============================================================================
// Module   : enemy_grid_renderer
// Purpose  : Staggered ROWS x COLS pop-up enemy grid with per-cell animation
//            state machines and a 3-stage sprite-ROM pixel pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module enemy_grid_renderer #(
    parameter int          COLS      = 3,
    parameter int          ROWS      = 3,
    parameter int          TILE_W    = 160,
    parameter int          TILE_H    = 120,
    parameter int          X0        = 40,
    parameter int          Y0        = 50,
    parameter int          GAP_X     = 10,
    parameter int          GAP_Y     = 10,
    parameter int          ROW_SHIFT = 25,
    parameter int          RISE_STEP = 8,
    parameter int          UP_TICKS  = 60,
    parameter int          HIT_TICKS = 20,
    parameter int          TICK_LINE = 480,
    parameter logic [11:0] KEY_COLOR = 12'h000,
    parameter int          ADDR_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [9:0]               h_cnt_i,
    input  logic [9:0]               v_cnt_i,
    input  logic [ROWS*COLS-1:0]     spawn_i,
    input  logic [ROWS*COLS-1:0]     hit_i,
    output logic [ADDR_W-1:0]        rom_addr_o,
    input  logic [11:0]              rom_data_i,
    output logic [11:0]              pixel_o,
    output logic                     pixel_valid_o,
    output logic [ROWS*COLS-1:0]     cell_up_o,
    output logic                     score_pulse_o,
    output logic                     escape_pulse_o
);
    localparam int c_NCELL = ROWS * COLS;
    localparam int c_VIS_W = $clog2(TILE_H + 1);
    localparam int c_FRAME = TILE_W * TILE_H;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RISING  = 3'd1,
        S_UP      = 3'd2,
        S_FALLING = 3'd3,
        S_HIT     = 3'd4
    } state_t;

    state_t             state_q [c_NCELL];
    state_t             state_d [c_NCELL];
    logic [c_VIS_W-1:0] vis_q   [c_NCELL];
    logic [c_VIS_W-1:0] vis_d   [c_NCELL];
    logic [7:0]         timer_q [c_NCELL];
    logic [7:0]         timer_d [c_NCELL];
    logic               score_q, score_d;
    logic               escape_q, escape_d;

    logic               w_tick;
    logic [15:0]        w_vis_up, w_vis_dn;
    logic [7:0]         w_tdec;

    assign w_tick = (h_cnt_i == 10'd0) && (v_cnt_i == 10'(TICK_LINE));

    always_comb begin
        score_d  = 1'b0;
        escape_d = 1'b0;
        w_vis_up = '0;
        w_vis_dn = '0;
        w_tdec   = '0;
        for (int i = 0; i < c_NCELL; i++) begin
            state_d[i] = state_q[i];
            vis_d[i]   = vis_q[i];
            timer_d[i] = timer_q[i];
            w_vis_up   = 16'(vis_q[i]) + 16'(RISE_STEP);
            w_vis_dn   = (16'(vis_q[i]) > 16'(RISE_STEP)) ? 16'(vis_q[i]) - 16'(RISE_STEP) : 16'd0;
            w_tdec     = (timer_q[i] == 8'd0) ? 8'd0 : timer_q[i] - 8'd1;
            case (state_q[i])
                S_IDLE: begin
                    vis_d[i] = '0;
                    if (spawn_i[i]) state_d[i] = S_RISING;
                end
                S_RISING, S_UP, S_FALLING: begin
                    // A hit pre-empts any tick update in the same cycle.
                    if (hit_i[i]) begin
                        state_d[i] = S_HIT;
                        timer_d[i] = 8'(HIT_TICKS);
                        score_d    = 1'b1;
                    end else if (w_tick) begin
                        if (state_q[i] == S_RISING) begin
                            if (w_vis_up >= 16'(TILE_H)) begin
                                vis_d[i]   = c_VIS_W'(TILE_H);
                                state_d[i] = S_UP;
                                timer_d[i] = 8'(UP_TICKS);
                            end else begin
                                vis_d[i] = c_VIS_W'(w_vis_up);
                            end
                        end else if (state_q[i] == S_UP) begin
                            timer_d[i] = w_tdec;
                            if (w_tdec == 8'd0) state_d[i] = S_FALLING;
                        end else begin
                            vis_d[i] = c_VIS_W'(w_vis_dn);
                            if (w_vis_dn == 16'd0) begin
                                state_d[i] = S_IDLE;
                                escape_d   = 1'b1;
                            end
                        end
                    end
                end
                S_HIT: begin
                    if (w_tick) begin
                        timer_d[i] = w_tdec;
                        if (w_tdec == 8'd0) begin
                            state_d[i] = S_IDLE;
                            vis_d[i]   = '0;
                        end
                    end
                end
                default: begin
                    state_d[i] = S_IDLE;
                    vis_d[i]   = '0;
                    timer_d[i] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NCELL; i++) begin
                state_q[i] <= S_IDLE;
                vis_q[i]   <= '0;
                timer_q[i] <= '0;
            end
            score_q  <= 1'b0;
            escape_q <= 1'b0;
        end else begin
            for (int i = 0; i < c_NCELL; i++) begin
                state_q[i] <= state_d[i];
                vis_q[i]   <= vis_d[i];
                timer_q[i] <= timer_d[i];
            end
            score_q  <= score_d;
            escape_q <= escape_d;
        end
    end

    logic [c_NCELL-1:0] w_inside, w_show;
    logic [ADDR_W-1:0]  w_addr [c_NCELL];

    for (genvar gi = 0; gi < c_NCELL; gi++) begin : g_cell
        localparam int c_R = gi / COLS;
        localparam int c_C = gi % COLS;
        localparam int c_L = X0 + c_R * ROW_SHIFT + c_C * (TILE_W + GAP_X);
        localparam int c_T = Y0 + c_R * (TILE_H + GAP_Y);

        logic [15:0] w_tx, w_ty, w_hide, w_sy;
        logic [31:0] w_base;

        assign w_tx   = 16'(h_cnt_i) - 16'(c_L);
        assign w_ty   = 16'(v_cnt_i) - 16'(c_T);
        // Rows above the revealed band; the sprite grows up from the tile bottom.
        assign w_hide = 16'(TILE_H) - 16'(vis_q[gi]);
        assign w_sy   = w_ty - w_hide;
        assign w_inside[gi] = (16'(h_cnt_i) >= 16'(c_L)) && (16'(h_cnt_i) < 16'(c_L + TILE_W))
                           && (16'(v_cnt_i) >= 16'(c_T)) && (16'(v_cnt_i) < 16'(c_T + TILE_H));
        assign w_show[gi]   = w_inside[gi] && (w_ty >= w_hide);
        assign w_base       = (state_q[gi] == S_HIT) ? 32'(c_FRAME) : 32'd0;
        assign w_addr[gi]   = ADDR_W'(w_base + 32'(w_sy) * 32'(TILE_W) + 32'(w_tx));
        assign cell_up_o[gi] = (state_q[gi] != S_IDLE);
    end

    logic              w_sel_show;
    logic [ADDR_W-1:0] w_sel_addr;

    always_comb begin
        w_sel_show = 1'b0;
        w_sel_addr = '0;
        for (int i = c_NCELL - 1; i >= 0; i--) begin
            if (w_inside[i]) begin
                w_sel_show = w_show[i];
                w_sel_addr = w_addr[i];
            end
        end
    end

    logic [ADDR_W-1:0] rom_addr_q;
    logic              vis1_q, vis2_q, pixel_valid_q;
    logic [11:0]       pixel_q;
    logic              w_opaque;

    assign w_opaque = vis2_q && (rom_data_i != KEY_COLOR);

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr_q    <= '0;
            vis1_q        <= 1'b0;
            vis2_q        <= 1'b0;
            pixel_q       <= '0;
            pixel_valid_q <= 1'b0;
        end else begin
            rom_addr_q    <= w_sel_show ? w_sel_addr : '0;
            vis1_q        <= w_sel_show;
            vis2_q        <= vis1_q;
            pixel_valid_q <= w_opaque;
            pixel_q       <= w_opaque ? rom_data_i : 12'h000;
        end
    end

    assign rom_addr_o     = rom_addr_q;
    assign pixel_o        = pixel_q;
    assign pixel_valid_o  = pixel_valid_q;
    assign score_pulse_o  = score_q;
    assign escape_pulse_o = escape_q;

endmodule
`default_nettype wire

// File: tb/tb_enemy_grid_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_enemy_grid_renderer
// Purpose  : Directed, table-driven bench for enemy_grid_renderer (defaults).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_enemy_grid_renderer;
    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  h_cnt, v_cnt;
    logic [8:0]  spawn, hit;
    logic [15:0] rom_addr;
    logic [11:0] rom_data;
    logic [11:0] pixel;
    logic        pixel_valid;
    logic [8:0]  cell_up;
    logic        score_pulse, escape_pulse;
    logic        force_key;

    int n_checks  = 0;
    int n_pass    = 0;
    int score_cnt = 0;
    int esc_cnt   = 0;

    always #5 clk = ~clk;

    enemy_grid_renderer dut (
        .clk            (clk),
        .rst            (rst),
        .h_cnt_i        (h_cnt),
        .v_cnt_i        (v_cnt),
        .spawn_i        (spawn),
        .hit_i          (hit),
        .rom_addr_o     (rom_addr),
        .rom_data_i     (rom_data),
        .pixel_o        (pixel),
        .pixel_valid_o  (pixel_valid),
        .cell_up_o      (cell_up),
        .score_pulse_o  (score_pulse),
        .escape_pulse_o (escape_pulse)
    );

    // ROM content never equals the key colour unless forced.
    function automatic logic [11:0] rom_val(input logic [15:0] a);
        return {a[10:0], 1'b1};
    endfunction

    always @(posedge clk) rom_data <= force_key ? 12'h000 : rom_val(rom_addr);

    always @(posedge clk) begin
        #1;
        if (score_pulse === 1'b1)  score_cnt++;
        if (escape_pulse === 1'b1) esc_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic park();
        h_cnt = 10'd700;
        v_cnt = 10'd500;
    endtask

    task automatic tick();
        @(negedge clk);
        h_cnt = 10'd0;
        v_cnt = 10'd480;
        @(negedge clk);
        park();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic probe(input logic [9:0] h, input logic [9:0] v,
                         output logic [15:0] a, output logic val, output logic [11:0] pix);
        @(negedge clk);
        h_cnt = h;
        v_cnt = v;
        @(negedge clk);
        a = rom_addr;
        park();
        @(negedge clk);
        @(negedge clk);
        val = pixel_valid;
        pix = pixel;
    endtask

    typedef struct {
        int          ph;
        logic [9:0]  h;
        logic [9:0]  v;
        logic [15:0] addr;
        logic        valid;
    } vec_t;

    vec_t vecs[$];

    task automatic run_phase(input int ph);
        logic [15:0] a;
        logic        val;
        logic [11:0] pix;
        logic [11:0] exp_pix;
        foreach (vecs[k]) begin
            if (vecs[k].ph == ph) begin
                probe(vecs[k].h, vecs[k].v, a, val, pix);
                exp_pix = vecs[k].valid ? rom_val(vecs[k].addr) : 12'h000;
                check($sformatf("p%0d_addr(%0d,%0d)", ph, vecs[k].h, vecs[k].v), 32'(a), 32'(vecs[k].addr));
                check($sformatf("p%0d_valid(%0d,%0d)", ph, vecs[k].h, vecs[k].v), 32'(val), 32'(vecs[k].valid));
                check($sformatf("p%0d_pixel(%0d,%0d)", ph, vecs[k].h, vecs[k].v), 32'(pix), 32'(exp_pix));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] a;
        logic        val;
        logic [11:0] pix;
        int          errs;

        // Phase 1: cells 0 and 4 rising, vis=8 after one tick.
        vecs.push_back('{1, 10'd40,  10'd165, 16'd480,   1'b1});
        vecs.push_back('{1, 10'd40,  10'd161, 16'd0,     1'b0});
        vecs.push_back('{1, 10'd41,  10'd162, 16'd1,     1'b1});
        vecs.push_back('{1, 10'd199, 10'd169, 16'd1279,  1'b1});
        vecs.push_back('{1, 10'd200, 10'd169, 16'd0,     1'b0});
        vecs.push_back('{1, 10'd240, 10'd299, 16'd1125,  1'b1});
        vecs.push_back('{1, 10'd234, 10'd299, 16'd0,     1'b0});
        // Phase 2: fully up after 15 ticks.
        vecs.push_back('{2, 10'd240, 10'd190, 16'd1605,  1'b1});
        vecs.push_back('{2, 10'd40,  10'd50,  16'd0,     1'b1});
        vecs.push_back('{2, 10'd235, 10'd180, 16'd0,     1'b1});
        vecs.push_back('{2, 10'd394, 10'd299, 16'd19199, 1'b1});
        vecs.push_back('{2, 10'd395, 10'd299, 16'd0,     1'b0});
        vecs.push_back('{2, 10'd210, 10'd50,  16'd0,     1'b0});
        // Phase 3: both cells in HIT, frame 1 offset.
        vecs.push_back('{3, 10'd40,  10'd165, 16'd37600, 1'b1});
        vecs.push_back('{3, 10'd240, 10'd190, 16'd20805, 1'b1});

        rst = 1'b1;
        park();
        spawn = '0;
        hit = '0;
        force_key = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cell_up", 32'(cell_up), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_pixel_valid", 32'(pixel_valid), 32'd0);
        check("rst_pixel", 32'(pixel), 32'd0);
        check("rst_score", 32'(score_pulse), 32'd0);
        check("rst_escape", 32'(escape_pulse), 32'd0);
        rst = 1'b0;

        errs = 0;
        for (int y = 0; y < 480; y += 20) begin
            for (int x = 0; x < 640; x += 20) begin
                probe(10'(x), 10'(y), a, val, pix);
                if (a !== 16'd0 || val !== 1'b0 || pix !== 12'h000) errs++;
            end
        end
        check("idle_scan_errors", 32'(errs), 32'd0);
        check("idle_cell_up", 32'(cell_up), 32'd0);

        @(negedge clk) spawn = 9'h011;
        @(negedge clk) spawn = '0;
        check("spawn_cell_up", 32'(cell_up), 32'h011);
        tick();
        run_phase(1);
        ticks(14);
        run_phase(2);
        check("up_cell_up", 32'(cell_up), 32'h011);

        @(negedge clk) hit = 9'h011;
        @(negedge clk) hit = '0;
        check("hit_score_high", 32'(score_pulse), 32'd1);
        @(negedge clk);
        check("hit_score_low", 32'(score_pulse), 32'd0);
        check("hit_score_count", 32'(score_cnt), 32'd1);
        run_phase(3);
        ticks(19);
        check("hit_still_up", 32'(cell_up), 32'h011);
        tick();
        check("hit_done_idle", 32'(cell_up), 32'd0);
        check("hit_no_escape", 32'(esc_cnt), 32'd0);

        @(negedge clk) spawn = 9'h100;
        @(negedge clk) spawn = '0;
        ticks(75);
        probe(10'd430, 10'd310, a, val, pix);
        check("c8_up_top_addr", 32'(a), 32'd0);
        check("c8_up_top_valid", 32'(val), 32'd1);
        force_key = 1'b1;
        probe(10'd435, 10'd320, a, val, pix);
        force_key = 1'b0;
        check("key_addr", 32'(a), 32'd1605);
        check("key_valid", 32'(val), 32'd0);
        check("key_pixel", 32'(pix), 32'd0);
        tick();
        probe(10'd430, 10'd317, a, val, pix);
        check("c8_fall_hidden", 32'(val), 32'd0);
        probe(10'd430, 10'd318, a, val, pix);
        check("c8_fall_edge_valid", 32'(val), 32'd1);
        check("c8_fall_edge_addr", 32'(a), 32'd0);
        ticks(13);
        check("c8_before_escape_up", 32'(cell_up), 32'h100);
        check("c8_before_escape_cnt", 32'(esc_cnt), 32'd0);
        tick();
        check("c8_escape_high", 32'(escape_pulse), 32'd1);
        @(negedge clk);
        check("c8_escape_low", 32'(escape_pulse), 32'd0);
        check("c8_escape_count", 32'(esc_cnt), 32'd1);
        check("c8_idle", 32'(cell_up), 32'd0);

        @(negedge clk) begin spawn = 9'h004; hit = 9'h004; end
        @(negedge clk) begin spawn = '0; hit = '0; end
        check("c2_spawn_hit_up", 32'(cell_up), 32'h004);
        check("c2_spawn_hit_no_score", 32'(score_pulse), 32'd0);
        @(negedge clk) hit = 9'h004;
        @(negedge clk) hit = '0;
        check("c2_hit_score", 32'(score_pulse), 32'd1);
        @(negedge clk) spawn = 9'h044;
        @(negedge clk) spawn = '0;
        check("c6_spawn_up", 32'(cell_up), 32'h044);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cell_up", 32'(cell_up), 32'd0);
        check("midrst_score", 32'(score_pulse), 32'd0);
        check("midrst_escape", 32'(escape_pulse), 32'd0);
        rst = 1'b0;
        probe(10'd90, 10'd429, a, val, pix);
        check("midrst_c6_addr", 32'(a), 32'd0);
        check("midrst_c6_valid", 32'(val), 32'd0);
        check("final_escape_count", 32'(esc_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
